// File: rtl/npc_pkg.sv
// Shared definitions for the NPC pipeline: branch codes, predictor counter states
// and the 2-bit saturating counter step.
package npc_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_BGE  = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == ST) ? ST : ctr + 2'd1;
        else
            return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bht_counter_array.sv
// Branch history table: array of 2-bit saturating counters with an asynchronous
// read port and one saturating update port.
module bht_counter_array
    import npc_pkg::*;
#(
    parameter int         ENTRIES = 64,
    parameter logic [1:0] INIT    = WNT,
    localparam int        IW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_idx,
    output logic [1:0]    rd_ctr,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic          wr_taken
);

    logic [1:0] ctr [ENTRIES];

    // Read-before-write falls out naturally: the read sees the stored value until the edge.
    assign rd_ctr = ctr[rd_idx];

    // NOTE: the table is a flop array, so every entry can be reset; the predictor
    // must start from a known bias rather than whatever power-up leaves behind.
    // NOTE: sequential state uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= INIT;
        end else if (wr_en) begin
            ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution for the pipelined NPC core: condition decode, BHT prediction,
// registered redirect/mispredict pulses and saturating statistics.
module branch_predict_unit
    import npc_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] BHT_INIT    = 2'b01,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pred_pc_i,
    output logic             pred_taken_o,
    input  logic             res_valid_i,
    input  logic [XLEN-1:0]  res_pc_i,
    input  logic [2:0]       res_branch_i,
    input  logic             res_zero_i,
    input  logic             res_less_i,
    input  logic             res_pred_taken_i,
    input  logic             flush_i,
    input  logic             stats_clr_i,
    output logic             pca_src_o,
    output logic             pcb_src_o,
    output logic             redirect_o,
    output logic             redirect_pca_o,
    output logic             redirect_pcb_o,
    output logic             mispredict_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mis_cnt_o
);

    localparam int IW = $clog2(BHT_ENTRIES);

    logic       taken;
    logic       cond;
    logic       v;
    logic       mis_n;
    logic       redirect_n;
    logic [1:0] rd_ctr;

    // Only the word-aligned index bits of either PC reach the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_i[XLEN-1:IW+2], pred_pc_i[1:0],
                              res_pc_i[XLEN-1:IW+2], res_pc_i[1:0]};

    bht_counter_array #(
        .ENTRIES (BHT_ENTRIES),
        .INIT    (BHT_INIT)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pred_pc_i[IW+1:2]),
        .rd_ctr   (rd_ctr),
        .wr_en    (v && cond),
        .wr_idx   (res_pc_i[IW+1:2]),
        .wr_taken (taken)
    );

    assign pred_taken_o = rd_ctr[1];

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        taken = 1'b0;
        unique case (res_branch_i)
            BR_JAL,
            BR_JALR: taken = 1'b1;
            BR_BEQ:  taken = res_zero_i;
            BR_BNE:  taken = !res_zero_i;
            BR_BLT:  taken = res_less_i;
            BR_BGE:  taken = !res_less_i;
            default: taken = 1'b0;
        endcase
    end

    assign cond      = res_branch_i[2];
    assign pcb_src_o = res_valid_i && taken;
    assign pca_src_o = res_valid_i && (res_branch_i == BR_JALR);

    assign v          = res_valid_i && !flush_i;
    assign mis_n      = v && cond && (taken != res_pred_taken_i);
    assign redirect_n = v && ((res_branch_i == BR_JAL) || (res_branch_i == BR_JALR) || mis_n);

    // A not-taken redirect has pcb_src_o=0 and pca_src_o=0, i.e. restart at PC+4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_o     <= 1'b0;
            redirect_pca_o <= 1'b0;
            redirect_pcb_o <= 1'b0;
            mispredict_o   <= 1'b0;
        end else begin
            redirect_o     <= redirect_n;
            redirect_pca_o <= redirect_n && pca_src_o;
            redirect_pcb_o <= redirect_n && pcb_src_o;
            mispredict_o   <= mis_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_o  <= '0;
            mis_cnt_o <= '0;
        end else if (stats_clr_i) begin
            br_cnt_o  <= '0;
            mis_cnt_o <= '0;
        end else begin
            if (v && cond && (br_cnt_o != '1))
                br_cnt_o <= br_cnt_o + CNT_W'(1);
            if (mis_n && (mis_cnt_o != '1))
                mis_cnt_o <= mis_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; statistics counters narrowed to 4 bits
// so saturation is reachable in a few cycles.
module tb_branch_predict_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic             res_valid;
    logic [31:0]      res_pc;
    logic [2:0]       res_branch;
    logic             res_zero;
    logic             res_less;
    logic             res_pred_taken;
    logic             flush;
    logic             stats_clr;
    logic             pca_src;
    logic             pcb_src;
    logic             redirect;
    logic             redirect_pca;
    logic             redirect_pcb;
    logic             mispredict;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    int checks = 0;
    int errors = 0;

    branch_predict_unit #(
        .XLEN        (32),
        .BHT_ENTRIES (64),
        .BHT_INIT    (2'b01),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_pc_i        (pred_pc),
        .pred_taken_o     (pred_taken),
        .res_valid_i      (res_valid),
        .res_pc_i         (res_pc),
        .res_branch_i     (res_branch),
        .res_zero_i       (res_zero),
        .res_less_i       (res_less),
        .res_pred_taken_i (res_pred_taken),
        .flush_i          (flush),
        .stats_clr_i      (stats_clr),
        .pca_src_o        (pca_src),
        .pcb_src_o        (pcb_src),
        .redirect_o       (redirect),
        .redirect_pca_o   (redirect_pca),
        .redirect_pcb_o   (redirect_pcb),
        .mispredict_o     (mispredict),
        .br_cnt_o         (br_cnt),
        .mis_cnt_o        (mis_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one resolution on the falling edge; it is consumed at the next rising edge.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] code,
                         input logic z, input logic l, input logic p, input logic f);
        @(negedge clk);
        res_valid      = v;
        res_pc         = pc;
        res_branch     = code;
        res_zero       = z;
        res_less       = l;
        res_pred_taken = p;
        flush          = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        res_valid = 1'b0;
        flush     = 1'b0;
        stats_clr = 1'b0;
        #1;
    endtask

    task automatic check_regs(input string tag, input logic rd, input logic ra,
                              input logic rb, input logic mp);
        check({tag, "_redirect"},     32'(redirect),     32'(rd));
        check({tag, "_redirect_pca"}, 32'(redirect_pca), 32'(ra));
        check({tag, "_redirect_pcb"}, 32'(redirect_pcb), 32'(rb));
        check({tag, "_mispredict"},   32'(mispredict),   32'(mp));
    endtask

    initial begin
        rst = 1'b1; pred_pc = 32'h8000_0000;
        res_valid = 0; res_pc = 0; res_branch = 3'b000; res_zero = 0; res_less = 0;
        res_pred_taken = 0; flush = 0; stats_clr = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_pred_taken", 32'(pred_taken), 0);
        check_regs("rst", 0, 0, 0, 0);
        check("rst_br_cnt", 32'(br_cnt), 0);
        check("rst_mis_cnt", 32'(mis_cnt), 0);

        // BEQ taken, predicted not-taken: entry 4 goes 01 -> 10
        pred_pc = 32'h8000_0010;
        drive(1, 32'h8000_0010, 3'b100, 1, 0, 0, 0);
        check("beq_pca", 32'(pca_src), 0);
        check("beq_pcb", 32'(pcb_src), 1);
        check("beq_pred_before", 32'(pred_taken), 0);
        tick();
        check_regs("beq_mis", 1, 0, 1, 1);
        check("beq_br_cnt", 32'(br_cnt), 1);
        check("beq_mis_cnt", 32'(mis_cnt), 1);
        check("beq_pred_after", 32'(pred_taken), 1);

        // Three more taken, now predicted taken: no mispredict, counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h8000_0010, 3'b100, 1, 0, 1, 0);
            tick();
            check("beq_hit_mispredict", 32'(mispredict), 0);
            check("beq_hit_redirect", 32'(redirect), 0);
        end
        check("beq_sat_pred", 32'(pred_taken), 1);
        check("beq_hit_br_cnt", 32'(br_cnt), 4);
        check("beq_hit_mis_cnt", 32'(mis_cnt), 1);

        // Not-taken against a taken prediction: redirect to PC+4, entry 11 -> 10
        drive(1, 32'h8000_0010, 3'b100, 0, 0, 1, 0);
        check("beq_nt_pcb", 32'(pcb_src), 0);
        tick();
        check_regs("beq_nt", 1, 0, 0, 1);
        check("beq_nt_pred", 32'(pred_taken), 1);
        check("beq_nt_br_cnt", 32'(br_cnt), 5);
        check("beq_nt_mis_cnt", 32'(mis_cnt), 2);

        // Pulses drop when nothing resolves
        idle();
        tick();
        check_regs("idle", 0, 0, 0, 0);

        // JALR: rs1 + imm, unconditional redirect, no BHT or stats effect
        pred_pc = 32'h8000_0020;
        drive(1, 32'h8000_0020, 3'b010, 0, 0, 0, 0);
        check("jalr_pca", 32'(pca_src), 1);
        check("jalr_pcb", 32'(pcb_src), 1);
        tick();
        check_regs("jalr", 1, 1, 1, 0);
        check("jalr_pred", 32'(pred_taken), 0);
        check("jalr_br_cnt", 32'(br_cnt), 5);
        check("jalr_mis_cnt", 32'(mis_cnt), 2);

        // JAL: PC + imm
        drive(1, 32'h8000_0020, 3'b001, 0, 0, 0, 0);
        check("jal_pca", 32'(pca_src), 0);
        check("jal_pcb", 32'(pcb_src), 1);
        tick();
        check_regs("jal", 1, 0, 1, 0);

        // Reserved code 011 behaves as no jump
        drive(1, 32'h8000_0020, 3'b011, 1, 1, 0, 0);
        check("rsv_pca", 32'(pca_src), 0);
        check("rsv_pcb", 32'(pcb_src), 0);
        tick();
        check_regs("rsv", 0, 0, 0, 0);

        // Invalid slot: combinational selects forced to 0
        drive(0, 32'h8000_0020, 3'b010, 0, 0, 0, 0);
        check("inv_pca", 32'(pca_src), 0);
        check("inv_pcb", 32'(pcb_src), 0);
        tick();
        check_regs("inv", 0, 0, 0, 0);

        // BGE taken but flushed: nothing changes (entry 12 stays 01)
        pred_pc = 32'h8000_0030;
        drive(1, 32'h8000_0030, 3'b111, 0, 0, 0, 1);
        tick();
        check_regs("flush", 0, 0, 0, 0);
        check("flush_pred", 32'(pred_taken), 0);
        check("flush_br_cnt", 32'(br_cnt), 5);
        check("flush_mis_cnt", 32'(mis_cnt), 2);

        // Same-cycle read and update of entry 5: old value now, new value after the edge
        pred_pc = 32'h8000_0014;
        drive(1, 32'h8000_0014, 3'b110, 0, 1, 0, 0);
        check("rbw_pred_old", 32'(pred_taken), 0);
        tick();
        check("rbw_pred_new", 32'(pred_taken), 1);
        check("rbw_mispredict", 32'(mispredict), 1);
        check("rbw_br_cnt", 32'(br_cnt), 6);
        check("rbw_mis_cnt", 32'(mis_cnt), 3);

        // Clear wins over a simultaneous increment
        drive(1, 32'h8000_0040, 3'b100, 1, 0, 0, 0);
        stats_clr = 1'b1;
        tick();
        check("clr_br_cnt", 32'(br_cnt), 0);
        check("clr_mis_cnt", 32'(mis_cnt), 0);
        check("clr_mispredict", 32'(mispredict), 1);
        idle();

        // 16 mispredicts saturate the 4-bit counters at 15
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'h8000_0040, 3'b100, 1, 0, 0, 0);
            tick();
        end
        check("sat_mis_cnt", 32'(mis_cnt), 15);
        check("sat_br_cnt", 32'(br_cnt), 15);

        // Asynchronous reset mid-operation with a redirect pending
        pred_pc = 32'h8000_0010;
        drive(1, 32'h8000_0020, 3'b001, 0, 0, 0, 0);
        check("pre_rst_pred", 32'(pred_taken), 1);
        tick();
        check("pre_rst_redirect", 32'(redirect), 1);
        #2;
        rst = 1'b1;
        #1;
        check_regs("midrst", 0, 0, 0, 0);
        check("midrst_br_cnt", 32'(br_cnt), 0);
        check("midrst_mis_cnt", 32'(mis_cnt), 0);
        check("midrst_pred", 32'(pred_taken), 0);
        idle();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
